// File: rtl/rdmx_header_inserter.sv
// Prepends a header beat (target address, sequence number, magic) to every TLAST-delimited
// packet; payload beats pass through combinationally.
module rdmx_header_inserter #(
  parameter int unsigned DW = 512
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic [63:0]       i_base_addr,
  input  logic [63:0]       i_window_bytes,
  input  logic [DW-1:0]     i_axis_in_tdata,
  input  logic [DW/8-1:0]   i_axis_in_tkeep,
  input  logic              i_axis_in_tlast,
  input  logic              i_axis_in_tvalid,
  output logic              o_axis_in_tready,
  output logic [DW-1:0]     o_axis_out_tdata,
  output logic [DW/8-1:0]   o_axis_out_tkeep,
  output logic              o_axis_out_tlast,
  output logic              o_axis_out_tvalid,
  input  logic              i_axis_out_tready,
  output logic [31:0]       o_packets_sent
);

  localparam int unsigned BPB = DW / 8;

  typedef enum logic {StHdr, StData} state_t;

  state_t        r_state, w_state_nxt;
  logic [63:0]   r_cur_addr;
  logic [31:0]   r_seq;
  logic [15:0]   r_beats;
  logic [31:0]   r_packets_sent;

  logic [DW-1:0] w_hdr;
  logic [63:0]   w_adv;
  logic [63:0]   w_next_addr;
  logic          w_wrap;
  logic          w_data_hs;
  logic          w_pkt_end;

  always_comb begin
    w_hdr          = '0;
    w_hdr[63:0]    = r_cur_addr;
    w_hdr[95:64]   = r_seq;
    w_hdr[111:96]  = 16'h5244;
  end

  // Address advances by whole beats, regardless of tkeep on the final beat.
  assign w_adv       = (64'(r_beats) + 64'd1) * 64'(BPB);
  assign w_next_addr = r_cur_addr + w_adv;
  assign w_wrap      = (i_window_bytes != 64'd0) &&
                       ((w_next_addr - i_base_addr) >= i_window_bytes);

  assign w_data_hs = (r_state == StData) && i_axis_in_tvalid && i_axis_out_tready;
  assign w_pkt_end = w_data_hs && i_axis_in_tlast;

  always_comb begin
    w_state_nxt       = r_state;
    o_axis_out_tdata  = w_hdr;
    o_axis_out_tkeep  = '1;
    o_axis_out_tlast  = 1'b0;
    o_axis_out_tvalid = 1'b0;
    o_axis_in_tready  = 1'b0;
    unique case (r_state)
      StHdr: begin
        // Header only goes out once a payload beat is already waiting upstream.
        o_axis_out_tvalid = i_axis_in_tvalid;
        if (i_axis_in_tvalid && i_axis_out_tready) w_state_nxt = StData;
      end
      StData: begin
        o_axis_out_tdata  = i_axis_in_tdata;
        o_axis_out_tkeep  = i_axis_in_tkeep;
        o_axis_out_tlast  = i_axis_in_tlast;
        o_axis_out_tvalid = i_axis_in_tvalid;
        o_axis_in_tready  = i_axis_out_tready;
        if (w_pkt_end) w_state_nxt = StHdr;
      end
      default: w_state_nxt = StHdr;
    endcase
    if (!i_resetn) begin
      o_axis_out_tvalid = 1'b0;
      o_axis_in_tready  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state        <= StHdr;
      r_cur_addr     <= i_base_addr;
      r_seq          <= '0;
      r_beats        <= '0;
      r_packets_sent <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pkt_end) begin
        r_cur_addr     <= w_wrap ? i_base_addr : w_next_addr;
        r_seq          <= r_seq + 32'd1;
        r_packets_sent <= r_packets_sent + 32'd1;
        r_beats        <= '0;
      end else if (w_data_hs) begin
        r_beats <= r_beats + 16'd1;
      end
    end
  end

  assign o_packets_sent = r_packets_sent;

endmodule
